weight_buffer_bank: RTL and testbench
=====================================

WEIGHT_BUFFER_BANK -- requirements
Module: weight_buffer_bank

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port weight_en, input, 32, one-hot filter-slot select from the CNN controller.
REQ-004 SHALL have port weight_dim, input, 6, element count per filter, legal range 1..32.
REQ-005 SHALL have port num_filt_i, input, 6, filters in layer, legal range 1..32.
REQ-006 SHALL have port wvalid_i, input, 1, weight beat valid.
REQ-007 SHALL have port wdata_i, input, 32, two 16-bit elements per beat; [15:0] first, [31:16] second.
REQ-008 SHALL have port clear_i, input, 1, start of new layer; drives the bank back to IDLE.
REQ-009 SHALL have port rd_en_i, input, 1, conv engine requests next element column.
REQ-010 SHALL have port rd_valid_o, output, 1, rdata_o valid.
REQ-011 SHALL have port rdata_o, output, 512, filter f element at [16f+15:16f].
REQ-012 SHALL have port rd_last_o, output, 1, asserted with column weight_dim-1.
REQ-013 SHALL have port loaded_o, output, 1, all num_filt_i filters full.
REQ-014 SHALL have port wr_err_o, output, 1, sticky write-error flag.

Function
REQ-015 SHALL implement states IDLE, LOAD, READY; IDLE->LOAD on first accepted write; LOAD->READY on the cycle after the last accepted write makes every filter f<num_filt_i hold count==weight_dim; loaded_o SHALL equal (state==READY).
REQ-016 SHALL accept a write when wvalid_i=1, weight_en is exactly one-hot (index f), f<num_filt_i, weight_dim is in 1..32, state is IDLE or LOAD, and count[f]<weight_dim.
REQ-017 On an accepted write SHALL store wdata_i[15:0] at address count[f]; SHALL store wdata_i[31:16] at count[f]+1 only if count[f]+1<weight_dim; count[f] SHALL increase by 1 or 2 accordingly, with any odd trailing element discarded silently.
REQ-018 SHALL reject a write and set wr_err_o when wvalid_i=1 and any of these holds: weight_en is zero or multi-hot, f>=num_filt_i, count[f]==weight_dim, state is READY, or weight_dim is 0 or >32.
REQ-019 SHALL, in READY with rd_en_i=1, read address rd_ptr from all 32 filters in parallel; rdata_o and rd_valid_o=1 SHALL appear the next cycle (1-cycle latency).
REQ-020 rd_valid_o SHALL be 0 on any cycle not following an accepted read; rdata_o SHALL hold its last value when rd_valid_o=0.
REQ-021 rd_ptr SHALL increment per read and wrap from weight_dim-1 to 0; rd_last_o=1 with the wrapped column; the state SHALL remain READY so weights are reused across image windows.
REQ-022 SHALL ignore rd_en_i in IDLE or LOAD and SHALL not flag an error for it.
REQ-023 Filters f>=num_filt_i SHALL output whatever their memory holds; the consumer ignores them.
REQ-024 clear_i SHALL take priority over all writes and reads on the same cycle, and SHALL zero all counts, rd_ptr, rd_valid_o, rd_last_o and wr_err_o and move to IDLE next cycle; memory contents SHALL be retained.
REQ-025 weight_dim and num_filt_i SHALL be held stable from clear_i until the next clear_i; behaviour on a mid-layer change is undefined beyond REQ-018.

Reset
REQ-026 rst=1 SHALL, at the next edge, force state IDLE, all counts and rd_ptr 0, and rd_valid_o, rd_last_o, loaded_o, wr_err_o and rdata_o 0.
REQ-027 rst SHALL take precedence over clear_i and all traffic; a mid-load reset SHALL discard progress, and the memory array SHALL not be reset.

Structure
REQ-028 cnn_pkg SHALL hold NUM_FILT=32, WDEPTH=32, DATA_W=16 and the bank state enum.
REQ-029 Storage SHALL be one generated sub-module weight_fifo per filter (2-element write port, 1-element registered read, element counter).

Verification
REQ-030 weight_dim=4, num_filt_i=2, 2 beats each to filters 0 and 1 -> loaded_o=1; then 4 rd_en_i -> rdata_o[15:0] = elements 0..3 in order, rd_last_o on the 4th read only.
REQ-031 weight_dim=5, one filter, 3 beats carrying 1..6 -> count 5, element 6 discarded, no error; reads return 1..5.
REQ-032 weight_en=32'h3 with wvalid_i=1 -> write dropped, wr_err_o=1 and stays set until clear_i.
REQ-033 READY, weight_dim=3, 7 consecutive reads -> columns 0,1,2,0,1,2,0, rd_last_o on reads 3 and 6.
REQ-034 clear_i and wvalid_i on the same cycle mid-LOAD -> write dropped, IDLE next cycle, loaded_o=0; a reload then succeeds.
REQ-035 rst pulsed while READY with a read outstanding -> rd_valid_o=0 next cycle and all outputs 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared sizing constants, bank state encoding and helpers for the CNN weight buffer.
package cnn_pkg;

  localparam int unsigned NUM_FILT = 32;
  localparam int unsigned WDEPTH   = 32;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned PTR_W    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReady
  } bank_state_e;

  function automatic logic is_onehot(input logic [NUM_FILT-1:0] v);
    return (v != '0) && ((v & (v - NUM_FILT'(1))) == '0);
  endfunction

endpackage

// File: rtl/weight_buffer_bank_if.sv
// Controller/engine-facing signal bundle of the weight buffer bank.
interface weight_buffer_bank_if;
  import cnn_pkg::*;

  logic [NUM_FILT-1:0]        weight_en;
  logic [5:0]                 weight_dim;
  logic [5:0]                 num_filt_i;
  logic                       wvalid_i;
  logic [2*DATA_W-1:0]        wdata_i;
  logic                       clear_i;
  logic                       rd_en_i;
  logic                       rd_valid_o;
  logic [NUM_FILT*DATA_W-1:0] rdata_o;
  logic                       rd_last_o;
  logic                       loaded_o;
  logic                       wr_err_o;

  modport master (
    output weight_en, weight_dim, num_filt_i, wvalid_i, wdata_i, clear_i, rd_en_i,
    input  rd_valid_o, rdata_o, rd_last_o, loaded_o, wr_err_o
  );

  modport slave (
    input  weight_en, weight_dim, num_filt_i, wvalid_i, wdata_i, clear_i, rd_en_i,
    output rd_valid_o, rdata_o, rd_last_o, loaded_o, wr_err_o
  );

endinterface

// File: rtl/weight_fifo.sv
// Per-filter weight store: 2-element write port, registered 1-element read, fill counter.
module weight_fifo
  import cnn_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [CNT_W-1:0]    dim,
  input  logic                rd_en,
  input  logic [PTR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]   rdata,
  output logic [CNT_W-1:0]    count,
  output logic [CNT_W-1:0]    count_next
);

  logic [DATA_W-1:0] mem [WDEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              second_ok;

  // Upper half of a beat is kept only while it still fits inside the filter.
  assign second_ok = (count_q + CNT_W'(1)) < dim;

  always_comb begin
    count_next = count_q;
    if (clear) begin
      count_next = '0;
    end else if (wr_en) begin
      count_next = count_q + (second_ok ? CNT_W'(2) : CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[PTR_W-1:0]] <= wdata[DATA_W-1:0];
      if (second_ok) begin
        mem[count_q[PTR_W-1:0] + PTR_W'(1)] <= wdata[2*DATA_W-1:DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[rd_addr];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/weight_buffer_bank.sv
// Bank of per-filter weight stores: one-hot loading from the controller, then
// column-parallel reads that wrap so the loaded weights are reused per window.
module weight_buffer_bank
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  weight_buffer_bank_if.slave  bus
);

  bank_state_e      state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             rd_valid_q;
  logic             rd_last_q;
  logic             wr_err_q;

  logic [CNT_W-1:0]    count      [NUM_FILT];
  logic [CNT_W-1:0]    count_next [NUM_FILT];
  logic [PTR_W-1:0]    sel_idx;
  logic                dim_ok;
  logic                accept;
  logic [NUM_FILT-1:0] wr_sel;
  logic                all_full_next;
  logic                rd_accept;
  logic                ptr_at_last;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_FILT; i++) begin
      if (bus.weight_en[i]) sel_idx = PTR_W'(i);
    end
  end

  assign dim_ok = (bus.weight_dim != '0) && (bus.weight_dim <= CNT_W'(WDEPTH));
  assign accept = bus.wvalid_i && !bus.clear_i && !rst && is_onehot(bus.weight_en) &&
                  ({1'b0, sel_idx} < bus.num_filt_i) && dim_ok && (state_q != StReady) &&
                  (count[sel_idx] < bus.weight_dim);
  assign wr_sel = accept ? bus.weight_en : '0;

  // Completion is judged on post-write counts so READY follows the final write directly.
  always_comb begin
    all_full_next = 1'b1;
    for (int i = 0; i < NUM_FILT; i++) begin
      if ((CNT_W'(i) < bus.num_filt_i) && (count_next[i] < bus.weight_dim)) begin
        all_full_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (accept) state_d = all_full_next ? StReady : StLoad;
        StLoad:  if (all_full_next) state_d = StReady;
        StReady: state_d = StReady;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.loaded_o   = (state_q == StReady);
    bus.rd_valid_o = rd_valid_q;
    bus.rd_last_o  = rd_last_q;
    bus.wr_err_o   = wr_err_q;
  end

  assign rd_accept   = (state_q == StReady) && bus.rd_en_i && !bus.clear_i;
  assign ptr_at_last = ({1'b0, rd_ptr_q} == (bus.weight_dim - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) begin
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      rd_last_q  <= rd_accept && ptr_at_last;
      if (rd_accept) rd_ptr_q <= ptr_at_last ? '0 : rd_ptr_q + PTR_W'(1);
      wr_err_q   <= wr_err_q || (bus.wvalid_i && !accept);
    end
  end

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
    weight_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (bus.clear_i),
      .wr_en      (wr_sel[f]),
      .wdata      (bus.wdata_i),
      .dim        (bus.weight_dim),
      .rd_en      (rd_accept),
      .rd_addr    (rd_ptr_q),
      .rdata      (bus.rdata_o[f*DATA_W +: DATA_W]),
      .count      (count[f]),
      .count_next (count_next[f])
    );
  end

endmodule

// File: tb/tb_weight_buffer_bank.sv
// Directed bench for weight_buffer_bank; read results are checked against a scoreboard queue.
module tb_weight_buffer_bank;
  import cnn_pkg::*;

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        chk1;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  weight_buffer_bank_if bus ();

  weight_buffer_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_layer(input logic [5:0] dim, input logic [5:0] nf);
    bus.weight_dim = dim;
    bus.num_filt_i = nf;
    bus.clear_i    = 1'b1;
    step();
    bus.clear_i    = 1'b0;
  endtask

  task automatic wr_raw(input logic [31:0] en, input logic [15:0] lo, input logic [15:0] hi);
    bus.weight_en = en;
    bus.wdata_i   = {hi, lo};
    bus.wvalid_i  = 1'b1;
    step();
    bus.wvalid_i  = 1'b0;
    bus.weight_en = '0;
  endtask

  task automatic wr(input int f, input logic [15:0] lo, input logic [15:0] hi);
    wr_raw(32'd1 << f, lo, hi);
  endtask

  // Compare one output cycle against the scoreboard head.
  task automatic collect(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 32'(bus.rd_valid_o), 32'(sb_q.size() != 0));
    if (bus.rd_valid_o && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_f0"}, 32'(bus.rdata_o[15:0]), 32'(e.d0));
      if (e.chk1) chk({tag, "_f1"}, 32'(bus.rdata_o[31:16]), 32'(e.d1));
      chk({tag, "_last"}, 32'(bus.rd_last_o), 32'(e.last));
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                    input logic c1, input logic last);
    sb_q.push_back('{d0: e0, d1: e1, chk1: c1, last: last});
    bus.rd_en_i = 1'b1;
    step();
    bus.rd_en_i = 1'b0;
    collect(tag);
  endtask

  initial begin
    logic [15:0] col3 [3];
    col3 = '{16'h00a1, 16'h00a2, 16'h00a3};
    bus.weight_en  = '0;
    bus.weight_dim = 6'd4;
    bus.num_filt_i = 6'd2;
    bus.wvalid_i   = 1'b0;
    bus.wdata_i    = '0;
    bus.clear_i    = 1'b0;
    bus.rd_en_i    = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_loaded", 32'(bus.loaded_o), 32'd0);
    chk("rst_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("rst_last", 32'(bus.rd_last_o), 32'd0);
    chk("rst_err", 32'(bus.wr_err_o), 32'd0);
    chk("rst_rdata", 32'(bus.rdata_o == '0), 32'd1);
    rst = 1'b0;

    // Two filters of four elements, then four reads.
    new_layer(6'd4, 6'd2);
    wr(0, 16'h0011, 16'h0012);
    chk("l30_loaded_a", 32'(bus.loaded_o), 32'd0);
    bus.rd_en_i = 1'b1;
    step();
    bus.rd_en_i = 1'b0;
    chk("l30_rd_in_load", 32'(bus.rd_valid_o), 32'd0);
    chk("l30_rd_in_load_err", 32'(bus.wr_err_o), 32'd0);
    wr(0, 16'h0013, 16'h0014);
    wr(1, 16'h0021, 16'h0022);
    chk("l30_loaded_b", 32'(bus.loaded_o), 32'd0);
    wr(1, 16'h0023, 16'h0024);
    chk("l30_loaded_c", 32'(bus.loaded_o), 32'd1);
    chk("l30_err", 32'(bus.wr_err_o), 32'd0);
    rd("r30_0", 16'h0011, 16'h0021, 1'b1, 1'b0);
    rd("r30_1", 16'h0012, 16'h0022, 1'b1, 1'b0);
    rd("r30_2", 16'h0013, 16'h0023, 1'b1, 1'b0);
    rd("r30_3", 16'h0014, 16'h0024, 1'b1, 1'b1);
    step();
    collect("r30_idle");
    chk("r30_hold", 32'(bus.rdata_o[15:0]), 32'h0014);

    // Odd element count: trailing element of the last beat is discarded.
    new_layer(6'd5, 6'd1);
    wr(0, 16'd1, 16'd2);
    wr(0, 16'd3, 16'd4);
    chk("l31_loaded_a", 32'(bus.loaded_o), 32'd0);
    wr(0, 16'd5, 16'd6);
    chk("l31_loaded_b", 32'(bus.loaded_o), 32'd1);
    chk("l31_err", 32'(bus.wr_err_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd($sformatf("r31_%0d", i), 16'(i + 1), 16'd0, 1'b0, 1'(i == 4));
    end
    wr(0, 16'h0077, 16'h0078);
    chk("l31_ready_wr_err", 32'(bus.wr_err_o), 32'd1);
    rd("r31_wrap", 16'd1, 16'd0, 1'b0, 1'b0);

    // Multi-hot select and out-of-range filter both flag a sticky error.
    new_layer(6'd4, 6'd1);
    chk("l32_clr_err", 32'(bus.wr_err_o), 32'd0);
    wr_raw(32'h3, 16'h0055, 16'h0056);
    chk("l32_err", 32'(bus.wr_err_o), 32'd1);
    chk("l32_state", 32'(bus.loaded_o), 32'd0);
    step();
    chk("l32_sticky", 32'(bus.wr_err_o), 32'd1);
    new_layer(6'd4, 6'd1);
    wr(1, 16'h0057, 16'h0058);
    chk("l32_range_err", 32'(bus.wr_err_o), 32'd1);

    // Back-to-back reads wrap every three columns.
    new_layer(6'd3, 6'd1);
    wr(0, col3[0], col3[1]);
    wr(0, col3[2], 16'h00ff);
    chk("l33_loaded", 32'(bus.loaded_o), 32'd1);
    bus.rd_en_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{d0: col3[i % 3], d1: 16'd0, chk1: 1'b0, last: 1'(i % 3 == 2)});
      step();
      if (i == 6) bus.rd_en_i = 1'b0;
      collect($sformatf("r33_%0d", i));
    end

    // Clear wins over a same-cycle write; a fresh load then succeeds.
    new_layer(6'd4, 6'd1);
    wr(0, 16'h0031, 16'h0032);
    bus.clear_i   = 1'b1;
    bus.wvalid_i  = 1'b1;
    bus.weight_en = 32'h1;
    bus.wdata_i   = {16'h0098, 16'h0099};
    step();
    bus.clear_i   = 1'b0;
    bus.wvalid_i  = 1'b0;
    bus.weight_en = '0;
    chk("l34_loaded", 32'(bus.loaded_o), 32'd0);
    chk("l34_err", 32'(bus.wr_err_o), 32'd0);
    wr(0, 16'h0041, 16'h0042);
    chk("l34_loaded_a", 32'(bus.loaded_o), 32'd0);
    wr(0, 16'h0043, 16'h0044);
    chk("l34_loaded_b", 32'(bus.loaded_o), 32'd1);
    rd("r34_0", 16'h0041, 16'd0, 1'b0, 1'b0);
    rd("r34_1", 16'h0042, 16'd0, 1'b0, 1'b0);
    rd("r34_2", 16'h0043, 16'd0, 1'b0, 1'b0);
    rd("r34_3", 16'h0044, 16'd0, 1'b0, 1'b1);

    // Reset with a read in flight clears every output.
    wr(0, 16'h0001, 16'h0002);
    chk("l35_pre_err", 32'(bus.wr_err_o), 32'd1);
    bus.rd_en_i = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.rd_en_i = 1'b0;
    chk("l35_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("l35_last", 32'(bus.rd_last_o), 32'd0);
    chk("l35_loaded", 32'(bus.loaded_o), 32'd0);
    chk("l35_err", 32'(bus.wr_err_o), 32'd0);
    chk("l35_rdata", 32'(bus.rdata_o == '0), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
